// File: rtl/keypad_debounce_encoder_if.sv
// Key-entry bundle between the raw numpad lines and the debounce/encode block.
interface keypad_debounce_encoder_if;
  logic       enable;
  logic [9:0] keypad;
  logic [3:0] bcd;
  logic       numpad_pressed;
  logic       key_strobe;
  logic       multi_key;

  modport master (output enable, keypad,
                  input  bcd, numpad_pressed, key_strobe, multi_key);
  modport slave  (input  enable, keypad,
                  output bcd, numpad_pressed, key_strobe, multi_key);
endinterface

// File: rtl/keypad_debounce_encoder.sv
// Debounces ten digit-key lines, encodes the held key to BCD and strobes once per press.
// Optional KEYPAD_SYNC_EN inserts a 2-flop synchronizer on every key line.
module keypad_debounce_encoder #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  keypad_debounce_encoder_if.slave  kif
);
  localparam logic [7:0] DC = 8'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {IDLE, DB_PRESS, PRESSED, DB_RELEASE} state_t;

  state_t     state, state_d;
  logic [7:0] cnt, cnt_d, cnt_inc;
  logic [3:0] cand, cand_d;
  logic [3:0] bcd_q, bcd_d;
  logic       strobe_q, strobe_d;
  logic       multi_q;
  logic [9:0] s;
  logic [3:0] ones, idx;
  logic       single, held;

`ifdef KEYPAD_SYNC_EN
  logic [9:0] sync1, sync2;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= kif.keypad;
      sync2 <= sync1;
    end
  end
  assign s = sync2;
`else
  assign s = kif.keypad;
`endif

  // Population count plus index of the (last) set bit; idx is only meaningful when single.
  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 10; i++) begin
      ones = ones + {3'b000, s[i]};
      if (s[i]) idx = 4'(i);
    end
  end

  assign single  = (ones == 4'd1);
  assign held    = s[cand];
  assign cnt_inc = cnt + 8'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cand     <= '0;
      bcd_q    <= '0;
      strobe_q <= 1'b0;
      multi_q  <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      cand     <= cand_d;
      bcd_q    <= bcd_d;
      strobe_q <= strobe_d;
      multi_q  <= (ones > 4'd1);
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cand_d   = cand;
    bcd_d    = bcd_q;
    strobe_d = 1'b0;
    unique case (state)
      IDLE: begin
        if (kif.enable && single) begin
          cand_d  = idx;
          cnt_d   = 8'd1;
          state_d = DB_PRESS;
        end
      end
      DB_PRESS: begin
        if (!kif.enable || !single || idx != cand) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_inc == DC) begin
          // Counter is left at DC-1; it is reloaded on the next debounce anyway.
          bcd_d    = cand;
          strobe_d = 1'b1;
          state_d  = PRESSED;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      PRESSED: begin
        if (!held) begin
          cnt_d   = 8'd1;
          state_d = DB_RELEASE;
        end
      end
      DB_RELEASE: begin
        if (held) begin
          cnt_d   = '0;
          state_d = PRESSED;
        end else if (cnt_inc == DC) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign kif.bcd            = bcd_q;
  assign kif.key_strobe     = strobe_q;
  assign kif.multi_key      = multi_q;
  assign kif.numpad_pressed = (state == PRESSED) || (state == DB_RELEASE);
endmodule

// File: tb/tb_keypad_debounce_encoder.sv
// Directed bench for keypad_debounce_encoder with DEBOUNCE_CYCLES=4.
module tb_keypad_debounce_encoder;
`ifdef KEYPAD_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_strb = 0;

  keypad_debounce_encoder_if kif ();

  keypad_debounce_encoder #(.DEBOUNCE_CYCLES(4)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif.slave)
  );

  always #5 clk = ~clk;

  // Strobe is a full-cycle pulse; mid-cycle sampling counts each one once.
  always @(negedge clk) if (kif.key_strobe === 1'b1) n_strb++;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  logic bseq [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic rseq [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    kif.enable = 1'b1;
    kif.keypad = '0;
    #1;
    chk("rst_bcd",   kif.bcd, 0);
    chk("rst_prs",   kif.numpad_pressed, 0);
    chk("rst_strb",  kif.key_strobe, 0);
    chk("rst_multi", kif.multi_key, 0);
    tick(1);
    rst = 1'b0;
    tick(1);

    // Clean press of key 5
    kif.keypad = 10'b0000100000;
    tick(3 + LAT);
    chk("cln_early", kif.numpad_pressed, 0);
    tick(1);
    chk("cln_strb",  kif.key_strobe, 1);
    chk("cln_prs",   kif.numpad_pressed, 1);
    chk("cln_bcd",   kif.bcd, 5);
    tick(1);
    chk("cln_strb0", kif.key_strobe, 0);
    tick(5);
    kif.keypad = '0;
    tick(3 + LAT);
    chk("cln_hold",  kif.numpad_pressed, 1);
    tick(1);
    chk("cln_rel",   kif.numpad_pressed, 0);
    chk("cln_bcdk",  kif.bcd, 5);
    chk("cln_nstrb", n_strb, 1);
    tick(2);

    // Bouncing key 7
    for (int i = 0; i < 7; i++) begin
      kif.keypad = bseq[i] ? 10'b0010000000 : 10'b0;
      tick(1);
      if (i == 5) chk("bnc_pre", kif.numpad_pressed, 0);
    end
    tick(LAT);
    chk("bnc_strb", kif.key_strobe, 1);
    chk("bnc_bcd",  kif.bcd, 7);
    for (int i = 0; i < 6; i++) begin
      kif.keypad = rseq[i] ? 10'b0010000000 : 10'b0;
      tick(1);
      if (i == 4) chk("bnc_rhold", kif.numpad_pressed, 1);
    end
    tick(LAT);
    chk("bnc_rel",   kif.numpad_pressed, 0);
    chk("bnc_nstrb", n_strb, 2);
    tick(2);

    // Chord from idle, then a second key added while pressed
    kif.keypad = 10'b0000001100;
    tick(1 + LAT);
    chk("chd_multi", kif.multi_key, 1);
    tick(5);
    chk("chd_prs",   kif.numpad_pressed, 0);
    chk("chd_bcd",   kif.bcd, 7);
    chk("chd_nstrb", n_strb, 2);
    kif.keypad = '0;
    tick(1 + LAT);
    chk("chd_multi0", kif.multi_key, 0);
    kif.keypad = 10'b0000000100;
    tick(4 + LAT);
    chk("chd_bcd2", kif.bcd, 2);
    kif.keypad = 10'b0000001100;
    tick(1 + LAT);
    chk("chd_add_multi", kif.multi_key, 1);
    tick(3);
    chk("chd_add_prs", kif.numpad_pressed, 1);
    chk("chd_add_bcd", kif.bcd, 2);
    kif.keypad = '0;
    tick(4 + LAT);
    chk("chd_rel",   kif.numpad_pressed, 0);
    chk("chd_nstrb2", n_strb, 3);
    tick(2);

    // Enable gating presses but not releases
    kif.enable = 1'b0;
    kif.keypad = 10'b0000010000;
    tick(6 + LAT);
    chk("en_prs",   kif.numpad_pressed, 0);
    chk("en_nstrb", n_strb, 3);
    kif.keypad = '0;
    kif.enable = 1'b1;
    tick(2 + LAT);
    kif.keypad = 10'b1000000000;
    tick(4 + LAT);
    chk("en_bcd9", kif.bcd, 9);
    kif.enable = 1'b0;
    tick(2);
    chk("en_hold", kif.numpad_pressed, 1);
    kif.keypad = '0;
    tick(3 + LAT);
    chk("en_rhold", kif.numpad_pressed, 1);
    tick(1);
    chk("en_rel",   kif.numpad_pressed, 0);
    chk("en_nstrb2", n_strb, 4);
    kif.enable = 1'b1;
    tick(2);

    // Asynchronous reset while key 1 is held
    kif.keypad = 10'b0000000010;
    tick(5 + LAT);
    chk("rmp_bcd1", kif.bcd, 1);
    #2 rst = 1'b1;
    #1;
    chk("rmp_prs",  kif.numpad_pressed, 0);
    chk("rmp_bcd0", kif.bcd, 0);
    chk("rmp_strb", kif.key_strobe, 0);
    tick(1);
    rst = 1'b0;
    tick(3 + LAT);
    chk("rmp_early", kif.numpad_pressed, 0);
    tick(1);
    chk("rmp_strb2", kif.key_strobe, 1);
    chk("rmp_bcd",   kif.bcd, 1);
    tick(1);
    chk("rmp_nstrb", n_strb, 6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/keypad_debounce_encoder.md
# keypad_debounce_encoder

- Front end of the microwave numpad path: takes ten raw digit-key lines (0–9), debounces them and encodes the held key to BCD.
- Produces the `numpad_pressed` level and a one-cycle `key_strobe` consumed by the key-entry pulse counter and by time-entry logic.
- Rejects bounces, glitches and multi-key chords, so downstream logic sees exactly one clean press/release per keystroke.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive samples required to accept a press or a release; legal range 2..255.
- `clk`  input  1: system clock; all state updates on rising edge.
- `rst`  input  1: asynchronous, active-high reset.
- `enable`  input  1: when low, new presses are not accepted.
- `keypad`  input  10: raw key lines, bit i high while digit i is held.
- `bcd`  output  4: code of last accepted key, range 0..9.
- `numpad_pressed`  output  1: high while an accepted key is considered held.
- `key_strobe`  output  1: one-cycle pulse on press acceptance.
- `multi_key`  output  1: registered flag, high when the sample had more than one key set.

## Operation
- Sampled vector `s` is `keypad`, or its synchronized copy when the sync stage is compiled in (see Configuration).
- "Single" means exactly one bit of `s` is set; its index is the candidate code. Internal counter is 8 bits, saturating at `DEBOUNCE_CYCLES`-1.
- **IDLE**: `numpad_pressed`=0.
  - If `enable`=1 and `s` is single: latch the index into `cand`, set cnt=1, go to DB_PRESS.
  - Otherwise stay in IDLE.
- **DB_PRESS**:
  - If `enable`=0, or `s` is not single, or `s` is single but index≠`cand`: go to IDLE and clear cnt.
  - Otherwise increment cnt.
  - On the sample where the matching count reaches `DEBOUNCE_CYCLES`: go to PRESSED, load `bcd`←`cand`, set `numpad_pressed`=1, pulse `key_strobe` for 1 cycle.
- **PRESSED**:
  - Stays while `s[cand]`=1. Extra keys pressed alongside are ignored apart from `multi_key`.
  - On the first sample with `s[cand]`=0: set cnt=1, go to DB_RELEASE.
- **DB_RELEASE**: `numpad_pressed` stays 1.
  - If `s[cand]`=1: return to PRESSED and clear cnt. No new strobe is issued.
  - Otherwise increment cnt. When `DEBOUNCE_CYCLES` consecutive low samples are reached: go to IDLE, `numpad_pressed`←0.
- `enable` does not affect PRESSED or DB_RELEASE: a held key always completes its release, so `numpad_pressed` is never truncated.
- `bcd` holds its value until the next accepted press. It is never changed in DB_PRESS.
- `multi_key` ← (popcount(`s`)>1) every cycle, in every state.

## Timing
- **Reset values**: state IDLE, cnt 0, `cand` 0, `bcd` 4'd0, `numpad_pressed` 0, `key_strobe` 0, `multi_key` 0, sync flops 0.
- Reset asserted mid-press drops all outputs immediately (asynchronously). After deassertion a still-held key needs a full new debounce.
- **Press latency**: `s` stable single from edge k → `numpad_pressed` and `key_strobe` high after edge k+`DEBOUNCE_CYCLES`-1; `key_strobe` low after edge k+`DEBOUNCE_CYCLES`.
- **Release latency**: `s[cand]` first seen low at edge r and held low → `numpad_pressed` low after edge r+`DEBOUNCE_CYCLES`-1.
- **Minimum strobe spacing**: 2×`DEBOUNCE_CYCLES` cycles.
- **Simultaneous events**: a key change on the same edge as acceptance is evaluated on the next sample. Acceptance wins for that edge.

## Configuration
- `KEYPAD_SYNC_EN` defined: `keypad` passes through a 2-flop synchronizer per bit before forming `s`. All press and release latencies grow by 2 cycles, and `multi_key` also lags `keypad` by 2 cycles.
- `KEYPAD_SYNC_EN` undefined: `s`=`keypad` directly. Used when the caller already synchronizes.

## Test plan
(Default `DEBOUNCE_CYCLES`=4, `KEYPAD_SYNC_EN` undefined.)
- **Clean press**: after reset, `keypad`=10'b0000100000 held 10 cycles → `bcd`=5, `key_strobe` exactly 1 cycle after 4th edge, `numpad_pressed` high; release → `numpad_pressed` low 4 edges later, `bcd` stays 5.
- **Bounce**: key 7 toggling 1,1,0,1,1,1,1 → single strobe, accepted 4 edges after the final rise, `bcd`=7; release bounce 0,1,0,0,0,0 → `numpad_pressed` stays high until the 4th consecutive low.
- **Chord**: keys 2 and 3 together from IDLE → `multi_key`=1, no strobe, `bcd` unchanged. Key 3 added while key 2 is in PRESSED → `multi_key`=1, `numpad_pressed` stays 1, no new strobe.
- **Enable**: `enable`=0 with key 4 held → no strobe. Drop `enable` while key 9 is in PRESSED → normal release, `numpad_pressed` falls on schedule.
- **Reset mid-press**: assert `rst` while PRESSED on key 1 → all outputs 0 asynchronously. Deassert with key 1 still held → fresh strobe 4 edges later.
- **Sync build**: define `KEYPAD_SYNC_EN`, repeat clean press → strobe arrives 2 cycles later than the unsynced build.
